// File: rtl/load_wb_ctrl_if.sv
// Data-memory read bus between the load sequencer and the memory.
//   mem_address     word-aligned read address
//   mem_read        read strobe, held with address/byteenable until accepted
//   mem_byteenable  byte lanes requested (little-endian lanes)
//   mem_waitrequest stall from memory; data is valid when it is low
//   mem_readdata    read data
interface load_wb_ctrl_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address, mem_read, mem_byteenable,
    input  mem_waitrequest, mem_readdata
  );

  modport slave (
    input  mem_address, mem_read, mem_byteenable,
    output mem_waitrequest, mem_readdata
  );
endinterface

// File: rtl/load_wb_ctrl.sv
// MIPS load sequencer and register-file write-port arbiter.
// Runs LB/LBU/LH/LHU/LW/LWL/LWR over the data-memory bus, extends or
// merges the loaded bytes into a full 32-bit word, and shares the single
// register-file write port with the ALU writeback path (load wins in WB).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start/opcode/eff_addr/rt/rt_old   load request and merge source
//   mem (master)        data-memory read bus
//   alu_wr_*            ALU writeback request
//   reg_write/reg_wr_*  register-file write port
//   alu_stall           ALU write deferred this cycle
//   busy/done/addr_error status
module load_wb_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] eff_addr,
  input  logic [4:0]  rt,
  input  logic [31:0] rt_old,
  load_wb_ctrl_if.master mem,
  input  logic        alu_wr_en,
  input  logic [4:0]  alu_wr_reg,
  input  logic [31:0] alu_wr_data,
  output logic        reg_write,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        alu_stall,
  output logic        busy,
  output logic        done,
  output logic        addr_error
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  rt_q;
  logic [31:0] res_q;

  logic        legal;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] res;
  logic [31:0] rd_sh;
  logic [4:0]  sh_lo;   // 8*off
  logic [4:0]  sh_hi;   // 8*(3-off)

  // Legality is judged on the raw request, before anything is latched.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: legal = 1'b1;
      OP_LH, OP_LHU:                 legal = ~eff_addr[0];
      OP_LW:                         legal = (eff_addr[1:0] == 2'b00);
      default:                       legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = legal ? S_REQ : S_ERR;
      S_REQ:  if (!mem.mem_waitrequest) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane selection and result formation from the latched request.
  always_comb begin
    off   = addr_q[1:0];
    sh_lo = {off, 3'b000};
    sh_hi = {~off, 3'b000};
    rd_sh = mem.mem_readdata >> sh_lo;
    be    = 4'b0000;
    res   = mem.mem_readdata;
    case (op_q)
      OP_LB: begin
        be  = 4'b0001 << off;
        res = {{24{rd_sh[7]}}, rd_sh[7:0]};
      end
      OP_LBU: begin
        be  = 4'b0001 << off;
        res = {24'h0, rd_sh[7:0]};
      end
      OP_LH: begin
        be  = 4'b0011 << off;
        res = {{16{rd_sh[15]}}, rd_sh[15:0]};
      end
      OP_LHU: begin
        be  = 4'b0011 << off;
        res = {16'h0, rd_sh[15:0]};
      end
      OP_LW: begin
        be  = 4'b1111;
        res = mem.mem_readdata;
      end
      // LWL: low off+1 memory bytes land in the top of rt; keep rt's low bytes.
      OP_LWL: begin
        be  = 4'b1111 >> (2'd3 - off);
        res = (mem.mem_readdata << sh_hi) | (rt_old & ((32'h1 << sh_hi) - 32'h1));
      end
      // LWR: high 4-off memory bytes land in the bottom of rt; keep rt's high bytes.
      OP_LWR: begin
        be  = 4'b1111 << off;
        res = rd_sh | (rt_old & ~(32'hFFFF_FFFF >> sh_lo));
      end
      default: begin
        be  = 4'b0000;
        res = mem.mem_readdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 6'h0;
      addr_q  <= 32'h0;
      rt_q    <= 5'h0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q   <= opcode;
        addr_q <= eff_addr;
        rt_q   <= rt;
      end
      // rt_old is taken here, so an ALU write retired earlier is merged.
      if (state_q == S_REQ && !mem.mem_waitrequest) res_q <= res;
    end
  end

  assign mem.mem_address    = {addr_q[31:2], 2'b00};
  assign mem.mem_read       = (state_q == S_REQ);
  assign mem.mem_byteenable = (state_q == S_REQ) ? be : 4'b0000;

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_WB);
  assign addr_error = (state_q == S_ERR);

  // Write-port arbitration; the load owns the port only in WB.
  always_comb begin
    reg_write   = 1'b0;
    reg_wr_addr = 5'h0;
    reg_wr_data = 32'h0;
    alu_stall   = 1'b0;
    if (!reset) begin
      if (state_q == S_WB) begin
        reg_write   = (rt_q != 5'h0);
        reg_wr_addr = rt_q;
        reg_wr_data = res_q;
        alu_stall   = alu_wr_en;
      end else begin
        reg_write   = alu_wr_en && (alu_wr_reg != 5'h0);
        reg_wr_addr = alu_wr_reg;
        reg_wr_data = alu_wr_data;
      end
    end
  end

endmodule
